mouse_cmd_sequencer: RTL

Queues host-issued PS/2 command bytes (set sample rate, set resolution, enable/disable reporting) and issues them to the mouse through the shared transmitter/receiver pair. It arbitrates ownership of that pair with the mouse master state machine, waits for the mouse acknowledge byte, retries on resend requests, and reports a per-command completion status. It sits beside the master state machine inside the mouse transceiver, between the processor bus bridge and the transmitter/receiver.

---
 rtl/mouse_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mouse_cmd_sequencer.sv
// mouse_cmd_sequencer
//
// Queues host PS/2 command bytes and plays them out to the mouse through the
// shared transmitter/receiver pair. For each command the sequencer takes
// ownership of the pair from the master state machine. It sends the byte and
// waits for the acknowledge. A resend request (0xFE) is retried up to
// MAX_RETRY times. One completion status is reported per command.
//
// Parameters:
//   FIFO_DEPTH      command queue depth (power of two, >= 2)
//   MAX_RETRY       resend retries allowed per command
//   TIMEOUT_CYCLES  watchdog limit in CLK cycles (24-bit counter)
//
// Optional feature macro:
//   MOUSE_CMD_SEQ_TIMEOUT_EN  when defined, the watchdog is built in and
//                             status 11 (timeout) is reachable. When it is not
//                             defined, the wait states wait forever.
//
// Ports:
//   CLK, RESET         rising-edge clock, synchronous active-high reset
//   CMD_VALID/BYTE     host command push, accepted while CMD_READY is high
//   CMD_READY          queue not full (combinational from the FIFO count)
//   OWN_REQ/OWN_GNT    ownership handshake with the master state machine
//   SEND_BYTE          one-cycle transmit strobe, data on BYTE_TO_SEND
//   BYTE_SENT          transmitter done pulse
//   READ_ENABLE        receiver enable while awaiting the acknowledge
//   BYTE_READ/BYTE_ERROR_CODE/BYTE_READY  receiver result
//   RESP_VALID/STATUS/CMD  one-cycle completion report
//   BUSY               sequencer is not idle
module mouse_cmd_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int MAX_RETRY      = 2,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CMD_VALID,
  input  logic [7:0] CMD_BYTE,
  output logic       CMD_READY,
  output logic       OWN_REQ,
  input  logic       OWN_GNT,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic       RESP_VALID,
  output logic [1:0] RESP_STATUS,
  output logic [7:0] RESP_CMD,
  output logic       BUSY
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [AW:0]   DEPTH_V     = (AW + 1)'(FIFO_DEPTH);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  localparam logic [1:0] STATUS_ACK     = 2'b00;
  localparam logic [1:0] STATUS_RETRY   = 2'b01;
  localparam logic [1:0] STATUS_ERR     = 2'b10;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SEND,
    ST_WAIT_SENT,
    ST_WAIT_ACK,
    ST_DONE
  } state_t;

  state_t        state;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   fifo_count;
  logic          push;
  logic          pop;
  logic          timeout;
  logic [7:0]    cmd_reg;
  logic [RW-1:0] retry_cnt;

  // The pointers carry one extra wrap bit, so their difference is the
  // occupancy. It stays unambiguous even when the queue is completely full.
  assign fifo_count   = wr_ptr - rd_ptr;
  assign CMD_READY    = (fifo_count != DEPTH_V);
  assign push         = CMD_VALID && CMD_READY;
  assign pop          = (state == ST_IDLE) && (fifo_count != '0);
  assign BYTE_TO_SEND = cmd_reg;
  assign RESP_CMD     = cmd_reg;

  // Queue pointers. A push and a pop in the same cycle move both pointers,
  // so the occupancy does not change.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Queue storage. It has no reset, because the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= CMD_BYTE;
  end

`ifdef MOUSE_CMD_SEQ_TIMEOUT_EN
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);
  logic [23:0] wd_count;

  assign timeout = (wd_count >= TIMEOUT_LAST);

  // Watchdog. It restarts on every transmit, including resends. It runs
  // across both wait states and holds at the limit, so a late BYTE_SENT
  // cannot push it past the compare point.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wd_count <= '0;
    end else if (state == ST_SEND) begin
      wd_count <= '0;
    end else if ((state == ST_WAIT_SENT || state == ST_WAIT_ACK) && !timeout) begin
      wd_count <= wd_count + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  // Command state machine. All outputs are registered: each output is
  // assigned together with the transition that enters the state it belongs to.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      cmd_reg     <= '0;
      retry_cnt   <= '0;
      OWN_REQ     <= 1'b0;
      SEND_BYTE   <= 1'b0;
      READ_ENABLE <= 1'b0;
      RESP_VALID  <= 1'b0;
      RESP_STATUS <= STATUS_ACK;
      BUSY        <= 1'b0;
    end else begin
      SEND_BYTE  <= 1'b0;
      RESP_VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cmd_reg   <= fifo_mem[rd_ptr[AW-1:0]];
            retry_cnt <= '0;
            OWN_REQ   <= 1'b1;
            BUSY      <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (OWN_GNT) begin
            SEND_BYTE <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          state <= ST_WAIT_SENT;
        end
        ST_WAIT_SENT: begin
          if (BYTE_SENT) begin
            READ_ENABLE <= 1'b1;
            state       <= ST_WAIT_ACK;
          end else if (timeout) begin
            RESP_STATUS <= STATUS_TIMEOUT;
            RESP_VALID  <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_WAIT_ACK: begin
          // A receiver byte has priority over a timeout in the same cycle.
          // A receive error makes the byte untrustworthy, so the error is
          // checked before the byte value.
          if (BYTE_READY) begin
            if (BYTE_ERROR_CODE != 2'b00 || BYTE_READ == 8'hFC) begin
              RESP_STATUS <= STATUS_ERR;
              RESP_VALID  <= 1'b1;
              READ_ENABLE <= 1'b0;
              state       <= ST_DONE;
            end else if (BYTE_READ == 8'hFA) begin
              RESP_STATUS <= STATUS_ACK;
              RESP_VALID  <= 1'b1;
              READ_ENABLE <= 1'b0;
              state       <= ST_DONE;
            end else if (BYTE_READ == 8'hFE) begin
              if (retry_cnt < RETRY_LIMIT) begin
                retry_cnt   <= retry_cnt + 1'b1;
                READ_ENABLE <= 1'b0;
                SEND_BYTE   <= 1'b1;
                state       <= ST_SEND;
              end else begin
                RESP_STATUS <= STATUS_RETRY;
                RESP_VALID  <= 1'b1;
                READ_ENABLE <= 1'b0;
                state       <= ST_DONE;
              end
            end
          end else if (timeout) begin
            RESP_STATUS <= STATUS_TIMEOUT;
            RESP_VALID  <= 1'b1;
            READ_ENABLE <= 1'b0;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          OWN_REQ <= 1'b0;
          BUSY    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
